perspective_pixel_map: RTL and testbench

Raster-scan inverse-mapping stage sitting directly downstream of the perspective parameter generator. On a frame start it latches the nine inverse coefficients and three row-rewind constants, then walks every display pixel (640x480, row-major). For each pixel it computes the source coordinate (u,v) = (N_x/D, N_y/D) with incremental accumulators and a bit-serial divider. Each result is presented on a valid/ready stream to the frame-buffer read stage.

---
 rtl/perspective_pixel_map_if.sv | 21 ++
 rtl/perspective_pixel_map.sv | 244 ++++++++++++++++++++++++
 tb/tb_perspective_pixel_map.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perspective_pixel_map_if.sv
// Output pixel stream of perspective_pixel_map: one inverse-mapped pixel per
// valid/ready handshake, carrying destination and source coordinates.
interface perspective_pixel_map_if;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic [9:0] src_x;
    logic [8:0] src_y;
    logic       src_in_range;

    modport master (
        output out_valid, out_x, out_y, src_x, src_y, src_in_range,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, src_x, src_y, src_in_range,
        output out_ready
    );
endinterface

// File: rtl/perspective_pixel_map.sv
// perspective_pixel_map: raster-scan inverse mapping. Walks every display
// pixel, tracks N_x, N_y, D with incremental accumulators and produces
// (u,v) = floor(|N|/|D|) with a 10-step restoring divider per pixel.
// Optional build macro PIXMAP_CLAMP_EN: out-of-range source coordinates
// saturate to the frame edges instead of being forced to zero.
module perspective_pixel_map #(
    parameter int unsigned H_LAST = 639,
    parameter int unsigned V_LAST = 479
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [67:0]  p1_inv,
    input  logic signed [68:0]  p2_inv,
    input  logic signed [78:0]  p3_inv,
    input  logic signed [67:0]  p4_inv,
    input  logic signed [68:0]  p5_inv,
    input  logic signed [78:0]  p6_inv,
    input  logic signed [58:0]  p7_inv,
    input  logic signed [59:0]  p8_inv,
    input  logic signed [70:0]  p9_inv,
    input  logic signed [78:0]  dec_numx_horiz,
    input  logic signed [78:0]  dec_numy_horiz,
    input  logic signed [70:0]  dec_denom_horiz,
    perspective_pixel_map_if.master pix,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned AW = 82;   // numerator accumulator width
    localparam int unsigned DW = 74;   // denominator accumulator width
    localparam int unsigned CW = 84;   // compare width, holds |D| << 10
    localparam int unsigned QW = 10;   // quotient width
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned KW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ABS, S_DIV, S_OUT, S_STEP
    } state_t;

    state_t state;

    logic signed [67:0] p1_q, p4_q;
    logic signed [68:0] p2_q, p5_q;
    logic signed [78:0] p3_q, p6_q;
    logic signed [58:0] p7_q;
    logic signed [59:0] p8_q;
    logic signed [70:0] p9_q;
    logic signed [78:0] decx_q, decy_q;
    logic signed [70:0] decd_q;

    logic signed [AW-1:0] acc_x, acc_y;
    logic signed [DW-1:0] acc_d;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;

    logic [AW-1:0] rem_x, rem_y;
    logic [DW-1:0] mag_d;
    logic [QW-1:0] q_x, q_y;
    logic [KW-1:0] k;
    logic          neg_x, neg_y, ovf_x, ovf_y, d_zero;

    logic [AW-1:0] abs_x_c, abs_y_c;
    logic [DW-1:0] abs_d_c;
    logic [CW-1:0] div_d_c;
    logic [AW-1:0] rem_x_c, rem_y_c;
    logic [QW-1:0] q_x_c, q_y_c;
    logic          in_range_c;
    logic [XW-1:0] sx_c;
    logic [YW-1:0] sy_c;
    logic          last_pix_c;

    // Magnitudes of the current accumulators, captured in ABS.
    always_comb begin
        abs_x_c = acc_x[AW-1] ? $unsigned(-acc_x) : $unsigned(acc_x);
        abs_y_c = acc_y[AW-1] ? $unsigned(-acc_y) : $unsigned(acc_y);
        abs_d_c = acc_d[DW-1] ? $unsigned(-acc_d) : $unsigned(acc_d);
    end

    // One restoring division step for bit k of both quotients.
    always_comb begin
        div_d_c = CW'(mag_d) << k;
        rem_x_c = rem_x;
        rem_y_c = rem_y;
        q_x_c   = q_x;
        q_y_c   = q_y;
        if (CW'(rem_x) >= div_d_c) begin
            rem_x_c  = AW'(CW'(rem_x) - div_d_c);
            q_x_c[k] = 1'b1;
        end
        if (CW'(rem_y) >= div_d_c) begin
            rem_y_c  = AW'(CW'(rem_y) - div_d_c);
            q_y_c[k] = 1'b1;
        end
    end

    // Range qualification and final source coordinate from the last step.
    always_comb begin
        in_range_c = !d_zero && !neg_x && !neg_y && !ovf_x && !ovf_y &&
                     (q_x_c <= QW'(H_LAST)) && (q_y_c <= QW'(V_LAST));
`ifdef PIXMAP_CLAMP_EN
        sx_c = '0;
        sy_c = '0;
        if (!d_zero) begin
            if (neg_x)
                sx_c = '0;
            else if (ovf_x || (q_x_c > QW'(H_LAST)))
                sx_c = XW'(H_LAST);
            else
                sx_c = XW'(q_x_c);
            if (neg_y)
                sy_c = '0;
            else if (ovf_y || (q_y_c > QW'(V_LAST)))
                sy_c = YW'(V_LAST);
            else
                sy_c = YW'(q_y_c);
        end
`else
        sx_c = in_range_c ? XW'(q_x_c) : '0;
        sy_c = in_range_c ? YW'(q_y_c) : '0;
`endif
        last_pix_c = (x == XW'(H_LAST)) && (y == YW'(V_LAST));
    end

    // Frame sequencer, accumulators, divider registers and output stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            p1_q <= '0; p2_q <= '0; p3_q <= '0;
            p4_q <= '0; p5_q <= '0; p6_q <= '0;
            p7_q <= '0; p8_q <= '0; p9_q <= '0;
            decx_q <= '0; decy_q <= '0; decd_q <= '0;
            acc_x            <= '0;
            acc_y            <= '0;
            acc_d            <= '0;
            x                <= '0;
            y                <= '0;
            rem_x            <= '0;
            rem_y            <= '0;
            mag_d            <= '0;
            q_x              <= '0;
            q_y              <= '0;
            k                <= '0;
            neg_x            <= 1'b0;
            neg_y            <= 1'b0;
            ovf_x            <= 1'b0;
            ovf_y            <= 1'b0;
            d_zero           <= 1'b0;
            pix.out_valid    <= 1'b0;
            pix.out_x        <= '0;
            pix.out_y        <= '0;
            pix.src_x        <= '0;
            pix.src_y        <= '0;
            pix.src_in_range <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p1_q <= p1_inv; p2_q <= p2_inv; p3_q <= p3_inv;
                        p4_q <= p4_inv; p5_q <= p5_inv; p6_q <= p6_inv;
                        p7_q <= p7_inv; p8_q <= p8_inv; p9_q <= p9_inv;
                        decx_q <= dec_numx_horiz;
                        decy_q <= dec_numy_horiz;
                        decd_q <= dec_denom_horiz;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_x <= AW'(p3_q);
                    acc_y <= AW'(p6_q);
                    acc_d <= DW'(p9_q);
                    x     <= '0;
                    y     <= '0;
                    state <= S_ABS;
                end
                S_ABS: begin
                    rem_x  <= abs_x_c;
                    rem_y  <= abs_y_c;
                    mag_d  <= abs_d_c;
                    neg_x  <= (acc_x != '0) && (acc_x[AW-1] != acc_d[DW-1]);
                    neg_y  <= (acc_y != '0) && (acc_y[AW-1] != acc_d[DW-1]);
                    ovf_x  <= CW'(abs_x_c) >= (CW'(abs_d_c) << QW);
                    ovf_y  <= CW'(abs_y_c) >= (CW'(abs_d_c) << QW);
                    d_zero <= (acc_d == '0);
                    q_x    <= '0;
                    q_y    <= '0;
                    k      <= KW'(QW - 1);
                    state  <= S_DIV;
                end
                S_DIV: begin
                    rem_x <= rem_x_c;
                    rem_y <= rem_y_c;
                    q_x   <= q_x_c;
                    q_y   <= q_y_c;
                    if (k == '0) begin
                        pix.out_valid    <= 1'b1;
                        pix.out_x        <= x;
                        pix.out_y        <= y;
                        pix.src_x        <= sx_c;
                        pix.src_y        <= sy_c;
                        pix.src_in_range <= in_range_c;
                        state            <= S_OUT;
                    end else begin
                        k <= k - KW'(1);
                    end
                end
                S_OUT: begin
                    if (pix.out_valid && pix.out_ready) begin
                        pix.out_valid <= 1'b0;
                        if (last_pix_c) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    if (x < XW'(H_LAST)) begin
                        acc_x <= acc_x + AW'(p1_q);
                        acc_y <= acc_y + AW'(p4_q);
                        acc_d <= acc_d + DW'(p7_q);
                        x     <= x + XW'(1);
                    end else begin
                        acc_x <= acc_x + AW'(p2_q) - AW'(decx_q);
                        acc_y <= acc_y + AW'(p5_q) - AW'(decy_q);
                        acc_d <= acc_d + DW'(p8_q) - DW'(decd_q);
                        x     <= '0;
                        y     <= y + YW'(1);
                    end
                    state <= S_ABS;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perspective_pixel_map.sv
// Directed bench for perspective_pixel_map on a reduced 16x8 raster so that
// whole frames fit in a short run.
module tb_perspective_pixel_map;

    localparam int H    = 15;
    localparam int V    = 7;
    localparam int NPIX = (H + 1) * (V + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [67:0] p1_inv, p4_inv;
    logic signed [68:0] p2_inv, p5_inv;
    logic signed [78:0] p3_inv, p6_inv;
    logic signed [58:0] p7_inv;
    logic signed [59:0] p8_inv;
    logic signed [70:0] p9_inv;
    logic signed [78:0] dec_numx_horiz, dec_numy_horiz;
    logic signed [70:0] dec_denom_horiz;
    logic               busy;
    logic               frame_done;

    perspective_pixel_map_if pix ();

    perspective_pixel_map #(.H_LAST(H), .V_LAST(V)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .p1_inv          (p1_inv),
        .p2_inv          (p2_inv),
        .p3_inv          (p3_inv),
        .p4_inv          (p4_inv),
        .p5_inv          (p5_inv),
        .p6_inv          (p6_inv),
        .p7_inv          (p7_inv),
        .p8_inv          (p8_inv),
        .p9_inv          (p9_inv),
        .dec_numx_horiz  (dec_numx_horiz),
        .dec_numy_horiz  (dec_numy_horiz),
        .dec_denom_horiz (dec_denom_horiz),
        .pix             (pix),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint c_p1, c_p2, c_p3, c_p4, c_p5, c_p6, c_p7, c_p8, c_p9;

    logic [9:0] g_ox, g_sx;
    logic [8:0] g_oy, g_sy;
    logic       g_ir;

    // Drive coefficient ports from the c_* set; rewinds are H * x-step.
    task automatic load_coeffs();
        p1_inv = c_p1; p2_inv = c_p2; p3_inv = c_p3;
        p4_inv = c_p4; p5_inv = c_p5; p6_inv = c_p6;
        p7_inv = c_p7; p8_inv = c_p8; p9_inv = c_p9;
        dec_numx_horiz  = c_p1 * H;
        dec_numy_horiz  = c_p4 * H;
        dec_denom_horiz = c_p7 * H;
    endtask

    task automatic set_identity();
        c_p1 = 1; c_p2 = 0; c_p3 = 0;
        c_p4 = 0; c_p5 = 1; c_p6 = 0;
        c_p7 = 0; c_p8 = 0; c_p9 = 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Wait (bounded) for a valid pixel, capture it, and let it handshake.
    task automatic get_pixel(output int lat);
        lat = 0;
        while (pix.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (pix.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pixel_timeout: out_valid=%b after %0d cycles, required 1", pix.out_valid, lat);
        end
        g_ox = pix.out_x; g_oy = pix.out_y;
        g_sx = pix.src_x; g_sy = pix.src_y;
        g_ir = pix.src_in_range;
        @(posedge clk); #1;
    endtask

    // Direct (non-incremental) evaluation of the mapping at pixel (px,py).
    function automatic void model(input int px, input int py,
                                  output logic [9:0] sx, output logic [8:0] sy,
                                  output logic ir);
        longint nx, ny, d, ax, ay, ad, qx, qy;
        logic ngx, ngy, ovx, ovy;
        nx = c_p3 + c_p1 * px + c_p2 * py;
        ny = c_p6 + c_p4 * px + c_p5 * py;
        d  = c_p9 + c_p7 * px + c_p8 * py;
        ax = (nx < 0) ? -nx : nx;
        ay = (ny < 0) ? -ny : ny;
        ad = (d < 0) ? -d : d;
        ngx = (nx != 0) && ((nx < 0) != (d < 0));
        ngy = (ny != 0) && ((ny < 0) != (d < 0));
        ovx = ax >= ad * 1024;
        ovy = ay >= ad * 1024;
        qx = (ad != 0) ? ax / ad : 0;
        qy = (ad != 0) ? ay / ad : 0;
        ir = (d != 0) && !ngx && !ngy && !ovx && !ovy && (qx <= H) && (qy <= V);
`ifdef PIXMAP_CLAMP_EN
        if (d == 0) begin
            sx = '0;
            sy = '0;
        end else begin
            sx = ngx ? 10'd0 : ((ovx || qx > H) ? 10'(H) : 10'(qx));
            sy = ngy ? 9'd0 : ((ovy || qy > V) ? 9'(V) : 9'(qy));
        end
`else
        sx = ir ? 10'(qx) : 10'd0;
        sy = ir ? 9'(qy) : 9'd0;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pix.out_ready = 1'b1;
        set_identity(); load_coeffs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (pix.out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, required 0 0 0", pix.out_valid, busy, frame_done);
        end
        checks++;
        if (pix.out_x !== 10'd0 || pix.out_y !== 9'd0 || pix.src_x !== 10'd0 ||
            pix.src_y !== 9'd0 || pix.src_in_range !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: out=(%0d,%0d) src=(%0d,%0d) ir=%b, required all 0",
                     pix.out_x, pix.out_y, pix.src_x, pix.src_y, pix.src_in_range);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (pix.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: valid=%b busy=%b, required 0 0", pix.out_valid, busy);
        end
    endtask

    task automatic test_identity();
        int lat, ex, ey;
        set_identity(); load_coeffs();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pix.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_busy: busy=%b valid=%b, required 1 0", busy, pix.out_valid);
        end
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (pix.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_valid_early: valid=%b at cycle 12, required 0", pix.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (pix.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_cycle13: valid=%b, required 1", pix.out_valid);
        end
        for (int i = 0; i < NPIX; i++) begin
            ex = i % (H + 1);
            ey = i / (H + 1);
            get_pixel(lat);
            if (i > 0) begin
                checks++;
                if (lat != 12) begin
                    errors++;
                    $display("FAIL identity_period: pixel %0d waited %0d cycles, required 12", i, lat);
                end
            end
            checks++;
            if (g_ox !== 10'(ex) || g_oy !== 9'(ey) || g_sx !== 10'(ex) ||
                g_sy !== 9'(ey) || g_ir !== 1'b1) begin
                errors++;
                $display("FAIL identity_pixel: got (%0d,%0d)->(%0d,%0d) ir=%b, required (%0d,%0d)->(%0d,%0d) ir=1",
                         g_ox, g_oy, g_sx, g_sy, g_ir, ex, ey, ex, ey);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_done: done=%b busy=%b, required 1 0", frame_done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b, required 0", frame_done);
        end
    endtask

    task automatic test_half_scale();
        int lat, ex, ey;
        logic [9:0] msx;
        logic [8:0] msy;
        logic       mir;
        set_identity(); c_p9 = 2; load_coeffs();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            ex = i % (H + 1);
            ey = i / (H + 1);
            get_pixel(lat);
            model(ex, ey, msx, msy, mir);
            checks++;
            if (g_sx !== msx || g_sy !== msy || g_ir !== mir) begin
                errors++;
                $display("FAIL half_model: pixel (%0d,%0d) src=(%0d,%0d) ir=%b, required (%0d,%0d) ir=%b",
                         ex, ey, g_sx, g_sy, g_ir, msx, msy, mir);
            end
            if (ex == 7 && ey == 5) begin
                checks++;
                if (g_sx !== 10'd3 || g_sy !== 9'd2 || g_ir !== 1'b1) begin
                    errors++;
                    $display("FAIL half_7_5: src=(%0d,%0d) ir=%b, required (3,2) ir=1", g_sx, g_sy, g_ir);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL half_done: done=%b, required 1", frame_done);
        end
    endtask

    task automatic test_negative();
        int lat, ex, ey;
        logic [9:0] msx;
        logic [8:0] msy;
        logic       mir;
        set_identity(); c_p3 = -5; load_coeffs();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            ex = i % (H + 1);
            ey = i / (H + 1);
            get_pixel(lat);
            model(ex, ey, msx, msy, mir);
            checks++;
            if (g_sx !== msx || g_sy !== msy || g_ir !== mir) begin
                errors++;
                $display("FAIL neg_model: pixel (%0d,%0d) src=(%0d,%0d) ir=%b, required (%0d,%0d) ir=%b",
                         ex, ey, g_sx, g_sy, g_ir, msx, msy, mir);
            end
            if (ey == 0 && ex < 5) begin
                checks++;
                if (g_ir !== 1'b0 || g_sx !== 10'd0) begin
                    errors++;
                    $display("FAIL neg_row0: pixel x=%0d src_x=%0d ir=%b, required 0 0", ex, g_sx, g_ir);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL neg_done: done=%b, required 1", frame_done);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [9:0] exp_sx;
`ifdef PIXMAP_CLAMP_EN
        exp_sx = 10'(H);
`else
        exp_sx = 10'd0;
`endif
        set_identity(); c_p3 = 700; load_coeffs();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            get_pixel(lat);
            if (i == 0) begin
                checks++;
                if (g_ir !== 1'b0 || g_sx !== exp_sx || g_sy !== 9'd0) begin
                    errors++;
                    $display("FAIL ovf_0_0: src=(%0d,%0d) ir=%b, required (%0d,0) ir=0", g_sx, g_sy, g_ir, exp_sx);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: done=%b, required 1", frame_done);
        end
    endtask

    task automatic test_zero_denom();
        int lat, bad;
        set_identity(); c_p9 = 0; load_coeffs();
        pulse_start();
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            get_pixel(lat);
            checks++;
            if (g_ir !== 1'b0 || g_sx !== 10'd0 || g_sy !== 9'd0) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL zero_denom: pixel %0d src=(%0d,%0d) ir=%b, required (0,0) ir=0", i, g_sx, g_sy, g_ir);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_denom_done: done=%b busy=%b, required 1 0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        set_identity(); c_p3 = 3; load_coeffs();
        pix.out_ready = 1'b0;
        pulse_start();
        lat = 0;
        while (pix.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 12 || pix.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: valid=%b after %0d cycles, required 1 after 12", pix.out_valid, lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (pix.out_valid !== 1'b1 || pix.out_x !== 10'd0 || pix.out_y !== 9'd0 ||
                pix.src_x !== 10'd3 || pix.src_in_range !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b out=(%0d,%0d) src_x=%0d ir=%b, required 1 (0,0) 3 1",
                         c, pix.out_valid, pix.out_x, pix.out_y, pix.src_x, pix.src_in_range);
            end
        end
        pix.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pix.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b after handshake, required 0", pix.out_valid);
        end
        get_pixel(lat);
        checks++;
        if (lat != 12 || g_ox !== 10'd1 || g_oy !== 9'd0 || g_sx !== 10'd4) begin
            errors++;
            $display("FAIL bp_next: lat=%0d out=(%0d,%0d) src_x=%0d, required 12 (1,0) 4", lat, g_ox, g_oy, g_sx);
        end
        reset_dut();
    endtask

    task automatic test_reset_midframe();
        int lat, seen;
        set_identity(); load_coeffs();
        pulse_start();
        for (int i = 0; i < 100; i++) get_pixel(lat);
        reset_dut();
        checks++;
        if (pix.out_valid !== 1'b0 || busy !== 1'b0 || pix.out_x !== 10'd0 ||
            pix.src_x !== 10'd0 || pix.src_in_range !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b out_x=%0d src_x=%0d ir=%b, required all 0",
                     pix.out_valid, busy, pix.out_x, pix.src_x, pix.src_in_range);
        end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (pix.out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_stays_idle: %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ex, ey;
        set_identity(); load_coeffs();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            ex = i % (H + 1);
            ey = i / (H + 1);
            get_pixel(lat);
            if (i == 5) begin
                p1_inv = 3; p3_inv = 100; p5_inv = -2; p9_inv = 7;
                p7_inv = 1; dec_numx_horiz = 45;
                pulse_start();
            end
            checks++;
            if (g_ox !== 10'(ex) || g_oy !== 9'(ey) || g_sx !== 10'(ex) ||
                g_sy !== 9'(ey) || g_ir !== 1'b1) begin
                errors++;
                $display("FAIL latched_coeffs: got (%0d,%0d)->(%0d,%0d) ir=%b, required (%0d,%0d)->(%0d,%0d) ir=1",
                         g_ox, g_oy, g_sx, g_sy, g_ir, ex, ey, ex, ey);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latched_done: done=%b busy=%b, required 1 0", frame_done, busy);
        end
        load_coeffs();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_half_scale();
        test_negative();
        test_overflow();
        test_zero_denom();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
